// File: rtl/mb_conf_builder_pkg.sv
// Shared constants, types and group-index helpers for the macroblock configuration builder.
package mb_conf_builder_pkg;

  localparam int unsigned NUM_GROUPS = 13;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned MB_CONF_W  = NUM_GROUPS * CNT_W;  // 91
  localparam int unsigned GRP_W      = 4;
  localparam int unsigned FG_W       = 3;
  localparam int unsigned NUM_SEL    = (NUM_GROUPS - 1) / 2;  // g_1..g_6

  // Group-index encoding: 0 = motion, 2k-1 = selected g_k, 2k = unselected g_k.
  localparam int unsigned GRP_MOTION     = 0;
  localparam int unsigned GRP_LAST_LEGAL = NUM_GROUPS - 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [NUM_GROUPS-1:0][CNT_W-1:0] cnt_arr_t;

  typedef enum logic [1:0] {
    StAccum,
    StEval,
    StPush
  } state_e;

  function automatic logic grp_legal(input logic [GRP_W-1:0] grp);
    return int'(grp) <= int'(GRP_LAST_LEGAL);
  endfunction

  function automatic int sel_idx(input int k);
    return 2 * k - 1;
  endfunction

  function automatic int unsel_idx(input int k);
    return 2 * k;
  endfunction

endpackage

// File: rtl/mb_conf_builder_if.sv
// Count input handshake and mb_conf_fifo write-side bundle.
interface mb_conf_builder_if;
  import mb_conf_builder_pkg::*;

  logic                 in_valid;
  logic [GRP_W-1:0]     in_group;
  logic                 in_sign;
  logic                 in_last;
  logic                 in_ready;
  logic                 mb_conf_afull;
  logic [MB_CONF_W-1:0] mb_conf;
  logic [FG_W-1:0]      first_group;
  logic                 has_one_group;
  logic                 mb_conf_wr;

  // Builder side.
  modport slave (
    input  in_valid, in_group, in_sign, in_last, mb_conf_afull,
    output in_ready, mb_conf, first_group, has_one_group, mb_conf_wr
  );

  // Producer / FIFO side.
  modport master (
    output in_valid, in_group, in_sign, in_last, mb_conf_afull,
    input  in_ready, mb_conf, first_group, has_one_group, mb_conf_wr
  );

endinterface

// File: rtl/mb_conf_builder_eval.sv
// Combinational classification of the 13 group counts of one macroblock.
module mb_conf_eval
  import mb_conf_builder_pkg::*;
(
  input  cnt_arr_t        cnt_i,
  output logic [FG_W-1:0] first_group_o,
  output logic            has_one_group_o,
  output logic            all_zero_o,
  output logic            drop_o
);

  logic [NUM_GROUPS-1:0] nz;
  logic [3:0]            num_nz;
  logic                  any_sel;
  logic                  any_unsel;

  // Nonzero map, population count and the selected/unselected summaries.
  always_comb begin
    num_nz    = '0;
    any_sel   = 1'b0;
    any_unsel = 1'b0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      nz[i]  = |cnt_i[i];
      num_nz = num_nz + {3'b000, nz[i]};
    end
    for (int k = 1; k <= NUM_SEL; k++) begin
      any_sel   = any_sel | nz[sel_idx(k)];
      any_unsel = any_unsel | nz[unsel_idx(k)];
    end
  end

  // Motion wins; otherwise the lowest selected group (scan downwards so smallest k sticks).
  always_comb begin
    first_group_o = '0;
    if (!nz[GRP_MOTION]) begin
      for (int k = NUM_SEL; k >= 1; k--) begin
        if (nz[sel_idx(k)]) first_group_o = FG_W'(k);
      end
    end
  end

  // Entry classification: empty, or only unselected groups present (unusable).
  always_comb begin
    has_one_group_o = (num_nz == 4'd1);
    all_zero_o      = ~|nz;
    drop_o          = !nz[GRP_MOTION] && !any_sel && any_unsel;
  end

endmodule

// File: rtl/mb_conf_builder.sv
// Accumulates signed group counts per macroblock and pushes one packed entry to mb_conf_fifo.
module mb_conf_builder
  import mb_conf_builder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  mb_conf_builder_if.slave    bus,
  output logic                sat_err,
  output logic                cfg_err
);

  state_e                 state_q, state_d;
  cnt_arr_t               cnt_q, cnt_d;
  logic [MB_CONF_W-1:0]   mb_conf_q, mb_conf_d;
  logic [FG_W-1:0]        first_group_q, first_group_d;
  logic                   has_one_group_q, has_one_group_d;
  logic                   sat_err_q, sat_err_d;
  logic                   cfg_err_q, cfg_err_d;

  logic [FG_W-1:0]        ev_first_group;
  logic                   ev_has_one_group;
  logic                   ev_all_zero;
  logic                   ev_drop;
  logic                   xfer;

  mb_conf_eval u_eval (
    .cnt_i           (cnt_q),
    .first_group_o   (ev_first_group),
    .has_one_group_o (ev_has_one_group),
    .all_zero_o      (ev_all_zero),
    .drop_o          (ev_drop)
  );

  assign bus.in_ready      = clk_en && (state_q == StAccum);
  assign xfer              = bus.in_valid && bus.in_ready;
  // Combinational so the write lands 2 cycles after the in_last transfer.
  assign bus.mb_conf_wr    = clk_en && (state_q == StPush) && !bus.mb_conf_afull;
  assign bus.mb_conf       = mb_conf_q;
  assign bus.first_group   = first_group_q;
  assign bus.has_one_group = has_one_group_q;
  assign sat_err           = sat_err_q;
  assign cfg_err           = cfg_err_q;

  // Next-state: accumulate, evaluate the finished macroblock, then wait for FIFO room.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mb_conf_d       = mb_conf_q;
    first_group_d   = first_group_q;
    has_one_group_d = has_one_group_q;
    sat_err_d       = sat_err_q;
    cfg_err_d       = cfg_err_q;  // a stall freezes the pulse as well
    if (clk_en) begin
      cfg_err_d = 1'b0;
      unique case (state_q)
        StAccum: begin
          if (xfer) begin
            if (!grp_legal(bus.in_group)) begin
              cfg_err_d = 1'b1;
            end else if (bus.in_sign) begin
              if (cnt_q[bus.in_group] == CNT_MAX) begin
                sat_err_d = 1'b1;
              end else begin
                cnt_d[bus.in_group] = cnt_q[bus.in_group] + 1'b1;
              end
            end
            if (bus.in_last) state_d = StEval;
          end
        end
        StEval: begin
          for (int i = 0; i < NUM_GROUPS; i++) begin
            mb_conf_d[MB_CONF_W-1-CNT_W*i -: CNT_W] = cnt_q[i];
          end
          first_group_d   = ev_first_group;
          has_one_group_d = ev_has_one_group;
          if (ev_all_zero || ev_drop) begin
            cnt_d     = '0;
            cfg_err_d = ev_drop;
            state_d   = StAccum;
          end else begin
            state_d = StPush;
          end
        end
        StPush: begin
          if (!bus.mb_conf_afull) begin
            cnt_d   = '0;
            state_d = StAccum;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StAccum;
        end
      endcase
    end
  end

  // State and registered outputs; reset discards any partial or pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StAccum;
      cnt_q           <= '0;
      mb_conf_q       <= '0;
      first_group_q   <= '0;
      has_one_group_q <= 1'b0;
      sat_err_q       <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mb_conf_q       <= mb_conf_d;
      first_group_q   <= first_group_d;
      has_one_group_q <= has_one_group_d;
      sat_err_q       <= sat_err_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_mb_conf_builder.sv
// Scoreboard bench for mb_conf_builder: directed macroblocks, monitor checks every FIFO write.
module tb_mb_conf_builder;
  import mb_conf_builder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic sat_err;
  logic cfg_err;

  mb_conf_builder_if bus ();

  mb_conf_builder dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .bus     (bus),
    .sat_err (sat_err),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MB_CONF_W-1:0] conf;
    logic [FG_W-1:0]      fg;
    logic                 one;
    bit                   chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_err      = 0;
  int   cyc        = 0;
  int   last_cyc   = 0;
  int   cfg_pulses = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue an expected entry with at most two nonzero counts (idx < 0 means unused).
  task automatic expect_mb(input int ia, input int va, input int ib, input int vb,
                           input int fg, input bit one, input bit chk_lat);
    exp_t e;
    e.conf = '0;
    if (ia >= 0) e.conf[MB_CONF_W-1-CNT_W*ia -: CNT_W] = CNT_W'(va);
    if (ib >= 0) e.conf[MB_CONF_W-1-CNT_W*ib -: CNT_W] = CNT_W'(vb);
    e.fg      = FG_W'(fg);
    e.one     = one;
    e.chk_lat = chk_lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [GRP_W-1:0] g, input logic s, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_group = g;
    bus.in_sign  = s;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: actual=in_ready low required=in_ready high");
    end
    @(posedge clk);
    #1;
    if (l) last_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every write pops the scoreboard; cfg_err pulses are tallied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_err) cfg_pulses++;
      if (bus.mb_conf_wr) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: actual=mb_conf_wr=1 required=no write");
        end else begin
          e = sb.pop_front();
          check("mb_conf", bus.mb_conf, e.conf);
          check("first_group", bus.first_group, e.fg);
          check("has_one_group", bus.has_one_group, e.one);
          if (e.chk_lat) check("wr_latency", cyc - (last_cyc - 1), 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst               = 1'b1;
    clk_en            = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_group      = '0;
    bus.in_sign       = 1'b0;
    bus.in_last       = 1'b0;
    bus.mb_conf_afull = 1'b0;
    idle(3);
    check("rst_mb_conf", bus.mb_conf, 0);
    check("rst_first_group", bus.first_group, 0);
    check("rst_has_one", bus.has_one_group, 0);
    check("rst_wr", bus.mb_conf_wr, 0);
    check("rst_sat_err", sat_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;

    // Five motion signs, with a stall in the middle.
    expect_mb(0, 5, -1, 0, 0, 1'b1, 1'b1);
    send(4'd0, 1'b1, 1'b0);
    send(4'd0, 1'b1, 1'b0);
    clk_en = 1'b0;
    @(negedge clk);
    check("stall_in_ready", bus.in_ready, 0);
    idle(3);
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) send(4'd0, 1'b1, 1'(i == 2));
    idle(4);

    // Groups 3,3,4 then a sign-less in_last.
    expect_mb(3, 2, 4, 1, 2, 1'b0, 1'b1);
    send(4'd3, 1'b1, 1'b0);
    send(4'd3, 1'b1, 1'b0);
    send(4'd4, 1'b1, 1'b0);
    send(4'd0, 1'b0, 1'b1);
    idle(4);

    // Saturation on group 1.
    expect_mb(1, 127, -1, 0, 1, 1'b1, 1'b1);
    for (int i = 0; i < 130; i++) begin
      send(4'd1, 1'b1, 1'(i == 129));
      if (i == 126) check("sat_err_after_127", sat_err, 0);
      if (i == 127) check("sat_err_after_128", sat_err, 1);
    end
    idle(4);

    // Only unsigned counts: no write, no cfg_err.
    p0 = cfg_pulses;
    send(4'd5, 1'b0, 1'b0);
    send(4'd2, 1'b0, 1'b0);
    send(4'd1, 1'b0, 1'b1);
    idle(5);
    check("zero_mb_cfg_pulses", cfg_pulses - p0, 0);
    check("sat_err_sticky", sat_err, 1);

    // Only unselected group 6: dropped with one cfg_err pulse.
    p0 = cfg_pulses;
    send(4'd6, 1'b1, 1'b0);
    send(4'd6, 1'b1, 1'b1);
    idle(5);
    check("drop_cfg_pulses", cfg_pulses - p0, 1);

    // Illegal group 14 is ignored but pulses cfg_err; entry still written.
    p0 = cfg_pulses;
    expect_mb(1, 1, -1, 0, 1, 1'b1, 1'b1);
    send(4'd14, 1'b1, 1'b0);
    send(4'd1, 1'b1, 1'b1);
    idle(5);
    check("illegal_cfg_pulses", cfg_pulses - p0, 1);

    // afull held for 10 cycles in PUSH.
    bus.mb_conf_afull = 1'b1;
    expect_mb(5, 1, -1, 0, 3, 1'b1, 1'b0);
    send(4'd5, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("afull_in_ready", bus.in_ready, 0);
      check("afull_no_wr", bus.mb_conf_wr, 0);
    end
    @(posedge clk);
    #1;
    bus.mb_conf_afull = 1'b0;
    @(negedge clk);
    check("wr_after_afull_drop", bus.mb_conf_wr, 1);
    idle(4);

    // Reset while an entry is pending in PUSH.
    bus.mb_conf_afull = 1'b1;
    send(4'd1, 1'b1, 1'b1);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("pushrst_mb_conf", bus.mb_conf, 0);
    check("pushrst_first_group", bus.first_group, 0);
    check("pushrst_has_one", bus.has_one_group, 0);
    check("pushrst_wr", bus.mb_conf_wr, 0);
    check("pushrst_sat_err", sat_err, 0);
    check("pushrst_cfg_err", cfg_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mb_conf_afull = 1'b0;
    idle(5);
    expect_mb(1, 1, -1, 0, 1, 1'b1, 1'b1);
    send(4'd1, 1'b1, 1'b1);
    idle(5);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mb_conf_builder.md
MB_CONF_BUILDER -- requirements
Module: mb_conf_builder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: clk_en  in  1  global stall; when low, no state changes and no write strobes.
REQ-004 SHALL have: in_valid  in  1  a tagged count is presented.
REQ-005 SHALL have: in_group  in  4  group index: 0 = motion, 2k-1 = selected g_k, 2k = unselected g_k (k = 1..6); values 13..15 are illegal.
REQ-006 SHALL have: in_sign  in  1  the count carries a sign.
REQ-007 SHALL have: in_last  in  1  last count of the macroblock.
REQ-008 SHALL have: in_ready  out  1  the count is accepted this cycle.
REQ-009 SHALL have: mb_conf_afull  in  1  almost_full flag of mb_conf_fifo.
REQ-010 SHALL have: mb_conf  out  91  packed counts; count[i] occupies [90-7i -: 7].
REQ-011 SHALL have: first_group  out  3  0 = motion group, k = selected g_k.
REQ-012 SHALL have: has_one_group  out  1  exactly one group is nonzero.
REQ-013 SHALL have: mb_conf_wr  out  1  single-cycle write strobe to mb_conf_fifo.
REQ-014 SHALL have: sat_err  out  1  sticky flag: a count saturated.
REQ-015 SHALL have: cfg_err  out  1  one-cycle pulse: an entry was dropped, or in_group was illegal.

Function
REQ-016 SHALL implement the FSM ACCUM -> EVAL -> PUSH -> ACCUM, advancing only when clk_en is high.
REQ-017 SHALL drive in_ready = clk_en && state==ACCUM; a transfer occurs when in_valid && in_ready.
REQ-018 SHALL, on each transfer with in_sign=1 and a legal in_group, increment count[in_group] (7 bit), saturating at 127 and setting sat_err.
REQ-019 SHALL count a transfer with in_sign=0 toward the macroblock but leave all counts unchanged.
REQ-020 SHALL ignore the count of a transfer with illegal in_group (13..15) and pulse cfg_err; that transfer still obeys in_last.
REQ-021 SHALL, on a transfer with in_last=1, include that transfer's increment and then go to EVAL.
REQ-022 SHALL, in EVAL (one cycle), register the outputs below and then go to PUSH.
- first_group = 0 if count[0]≠0, else the smallest k with count[2k-1]≠0.
- has_one_group = exactly one of the 13 counts is nonzero.
- mb_conf is registered from the counts.
REQ-023 SHALL, in EVAL, return to ACCUM with no write and the counts cleared when all counts are zero.
REQ-024 SHALL, in EVAL, drop the entry (no write), pulse cfg_err, clear the counts and return to ACCUM when count[0]=0, all odd counts are zero and any even count is nonzero.
REQ-025 SHALL, in PUSH, assert mb_conf_wr for exactly one cycle on the first cycle with clk_en && ~mb_conf_afull, clear all counts in that same cycle and return to ACCUM.
REQ-026 SHALL hold mb_conf, first_group and has_one_group stable from EVAL until the next EVAL.
REQ-027 SHALL give a latency of 2 cycles from the in_last transfer to mb_conf_wr when afull is low; the earliest next transfer is 3 cycles after the in_last transfer.
REQ-028 SHALL, while mb_conf_afull stays high, remain in PUSH indefinitely with in_ready low.
REQ-029 SHALL, when clk_en is low, force mb_conf_wr to 0 and freeze all state.

Reset
REQ-030 SHALL, on asynchronous assertion of rst, immediately enter ACCUM and zero all counts.
REQ-031 SHALL reset mb_conf=0, first_group=0, has_one_group=0, mb_conf_wr=0, sat_err=0 and cfg_err=0.
REQ-032 SHALL, on reset mid-macroblock or in PUSH, discard the partial or pending entry without a write.
REQ-033 SHALL first accept input on the first clk_en cycle after rst deasserts.

Structure
REQ-034 SHALL take the following shared-package constants and types:
- NUM_GROUPS=13, CNT_W=7, MB_CONF_W=91;
- the group-index encoding;
- the FSM state enum.
REQ-035 SHALL have one natural sub-module, mb_conf_eval, which is combinational and computes first_group, has_one_group and the drop conditions from the 13 counts.

Verification
REQ-036 SHALL cover: signs on groups 3,3,4, then in_last -> one write, count[3]=2, count[4]=1, first_group=2, has_one_group=0.
REQ-037 SHALL cover: 5 signs on group 0 with in_last on the 5th -> count[0]=5, first_group=0, has_one_group=1, mb_conf_wr 2 cycles after in_last.
REQ-038 SHALL cover: 130 signs on group 1 -> count[1]=127 and sat_err=1 after the 128th sign.
REQ-039 SHALL cover: a macroblock with only in_sign=0 counts -> no write; a macroblock with signs only on group 6 -> no write and a cfg_err pulse.
REQ-040 SHALL cover: mb_conf_afull high for 10 cycles in PUSH -> in_ready=0 and no write; the write occurs on the first cycle after afull drops.
REQ-041 SHALL cover: rst asserted in PUSH -> no write, all outputs 0, next macroblock counted from zero.
